alu_rr_sequencer: RTL and testbench

//  Two-requester round-robin arbiter and sequencer in front of the single tiny ALU.
//  - Accepts operations (A, B, op) from two requesters and grants one at a time.
//  - Drives the ALU start/op handshake and holds start until done.
//  - Returns the 16-bit result tagged with the requester id.
//  - Completes no_op/rst_op locally; aborts ALU ops that hang past a timeout.

---
 rtl/alu_rr_sequencer_if.sv | 42 ++++
 rtl/alu_rr_sequencer.sv | 142 ++++++++++++++
 tb/tb_alu_rr_sequencer.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_rr_sequencer_if.sv
// Request, response and ALU-side signals of the round-robin ALU sequencer.
// slave is the sequencer's view; master is the view of the surrounding requesters and ALU.
interface alu_rr_sequencer_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [7:0]  req0_a;
  logic [7:0]  req0_b;
  logic [2:0]  req0_op;
  logic        req1_valid;
  logic        req1_ready;
  logic [7:0]  req1_a;
  logic [7:0]  req1_b;
  logic [2:0]  req1_op;
  logic        rsp_valid;
  logic        rsp_id;
  logic [15:0] rsp_result;
  logic        rsp_err;
  logic        alu_start;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [2:0]  alu_op;
  logic        alu_done;
  logic [15:0] alu_result;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_result, rsp_err,
    output alu_start, alu_a, alu_b, alu_op,
    input  alu_done, alu_result
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_result, rsp_err,
    input  alu_start, alu_a, alu_b, alu_op,
    output alu_done, alu_result
  );
endinterface

// File: rtl/alu_rr_sequencer.sv
// Two-requester round-robin arbiter that sequences one operation at a time through a shared ALU,
// completing no/rst/illegal ops locally and aborting ALU ops that exceed TIMEOUT_CYCLES.
module alu_rr_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input logic               clk,
  input logic               reset,
  alu_rr_sequencer_if.slave bus
);
  localparam int unsigned     CntW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e          state_q, state_d;
  logic            last_grant_q, last_grant_d;
  logic            id_q, id_d;
  logic            err_q, err_d;
  logic [15:0]     result_q, result_d;
  logic [CntW-1:0] count_q, count_d, count_inc;
  logic [7:0]      a_q, a_d, b_q, b_d;
  logic [2:0]      op_q, op_d;
  logic            rsp_valid_q, rsp_id_q, rsp_err_q;
  logic [15:0]     rsp_result_q;

  logic            pick0, pick1, accept;
  logic [7:0]      sel_a, sel_b;
  logic [2:0]      sel_op;
  logic            sel_alu, sel_illegal;

  // On a tie the requester that did not win last time is chosen.
  assign pick0 = bus.req0_valid & (~bus.req1_valid | last_grant_q);
  assign pick1 = bus.req1_valid & (~bus.req0_valid | ~last_grant_q);

  assign bus.req0_ready = (state_q == StIdle) & ~reset & pick0;
  assign bus.req1_ready = (state_q == StIdle) & ~reset & pick1;
  assign accept         = bus.req0_ready | bus.req1_ready;

  assign sel_a     = pick1 ? bus.req1_a  : bus.req0_a;
  assign sel_b     = pick1 ? bus.req1_b  : bus.req0_b;
  assign sel_op    = pick1 ? bus.req1_op : bus.req0_op;
  assign count_inc = count_q + CntW'(1);

  always_comb begin
    sel_alu     = 1'b0;
    sel_illegal = 1'b0;
    unique case (sel_op)
      3'b001, 3'b010, 3'b011, 3'b100: sel_alu     = 1'b1;
      3'b101, 3'b110:                 sel_illegal = 1'b1;
      default:                        ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    err_d        = err_q;
    result_d     = result_q;
    count_d      = count_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          id_d         = pick1;
          last_grant_d = pick1;
          count_d      = '0;
          result_d     = '0;
          if (sel_alu) begin
            state_d = StBusy;
            err_d   = 1'b0;
            a_d     = sel_a;
            b_d     = sel_b;
            op_d    = sel_op;
          end else begin
            state_d = StResp;
            err_d   = sel_illegal;
          end
        end
      end
      StBusy: begin
        if (bus.alu_done) begin
          state_d  = StResp;
          result_d = bus.alu_result;
          err_d    = 1'b0;
        end else if (count_inc == CntMax) begin
          state_d  = StResp;
          result_d = '0;
          err_d    = 1'b1;
        end else begin
          count_d = count_inc;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      err_q        <= 1'b0;
      result_q     <= '0;
      count_q      <= '0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_result_q <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      err_q        <= err_d;
      result_q     <= result_d;
      count_q      <= count_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      // Response fields are forced to zero outside the one-cycle pulse.
      rsp_valid_q  <= (state_q == StResp);
      rsp_id_q     <= (state_q == StResp) & id_q;
      rsp_err_q    <= (state_q == StResp) & err_q;
      rsp_result_q <= (state_q == StResp) ? result_q : '0;
    end
  end

  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.alu_start  = (state_q == StBusy);
  assign bus.alu_a      = a_q;
  assign bus.alu_b      = b_q;
  assign bus.alu_op     = op_q;
endmodule

// File: tb/tb_alu_rr_sequencer.sv
// Self-checking bench: a transaction-timeline model predicts ready, ALU handshake and responses
// every cycle; directed scenarios additionally pin literal results.
module tb_alu_rr_sequencer;
  localparam int unsigned T = 16;
  localparam logic [2:0] OpNo = 3'b000, OpAdd = 3'b001, OpXor = 3'b011, OpMul = 3'b100;

  typedef struct packed {
    logic       v;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } req_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_rr_sequencer_if bus ();
  alu_rr_sequencer #(.TIMEOUT_CYCLES(T)) dut (.clk(clk), .reset(reset), .bus(bus));

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Model: timeline of the single in-flight transaction.
  int          next_free, busy_lo, busy_hi, done_cyc, rsp_cyc;
  int          force_lat = -1;  // -1 random, 0 never done, N done on Nth start cycle
  logic        last_g, rsp_id_m, rsp_err_m;
  logic [15:0] rsp_res_m, alu_res_m;
  logic [7:0]  hold_a, hold_b;
  logic [2:0]  hold_op;

  logic        o_rdy0, o_rdy1, o_start, o_rv, o_rid, o_rerr;
  logic [15:0] o_res;
  int          starts, rsps;
  req_t        none, r0, r1;
  int          ng;
  logic        gid [8];
  int          gcyc [8];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic req_t mk(input logic v, input logic [2:0] op, input logic [7:0] a,
                              input logic [7:0] b);
    req_t r;
    r.v  = v;
    r.op = op;
    r.a  = a;
    r.b  = b;
    return r;
  endfunction

  function automatic logic [15:0] alu_fn(input logic [2:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
    case (op)
      3'd1:    return {8'h0, a} + {8'h0, b};
      3'd2:    return {8'h0, a & b};
      3'd3:    return {8'h0, a ^ b};
      3'd4:    return {8'h0, a} * {8'h0, b};
      default: return 16'h0;
    endcase
  endfunction

  task automatic model_reset();
    next_free = cyc + 1;
    busy_lo   = 0;
    busy_hi   = -1;
    done_cyc  = -1;
    rsp_cyc   = -1;
    last_g    = 1'b1;
    hold_a    = '0;
    hold_b    = '0;
    hold_op   = '0;
  endtask

  task automatic accept(input logic g, input req_t r);
    int lat, k, sel;
    last_g   = g;
    rsp_id_m = g;
    if (r.op >= 3'd1 && r.op <= 3'd4) begin
      if (force_lat >= 0) lat = force_lat;
      else begin
        sel = int'($urandom_range(9));
        lat = (sel == 0) ? 0 : (sel == 1) ? int'(T) : int'($urandom_range(1, 5));
      end
      k         = (lat == 0) ? int'(T) : lat;
      busy_lo   = cyc + 1;
      busy_hi   = cyc + k;
      done_cyc  = (lat == 0) ? -1 : cyc + lat;
      alu_res_m = alu_fn(r.op, r.a, r.b);
      rsp_res_m = (lat == 0) ? 16'h0 : alu_res_m;
      rsp_err_m = (lat == 0);
      hold_a    = r.a;
      hold_b    = r.b;
      hold_op   = r.op;
    end else begin
      k         = 0;
      rsp_res_m = 16'h0;
      rsp_err_m = (r.op == 3'b101) || (r.op == 3'b110);
    end
    rsp_cyc   = cyc + k + 2;
    next_free = cyc + k + 2;
  endtask

  // One clock cycle: drive at posedge+1, compare at negedge, then advance the model.
  task automatic step(input req_t q0, input req_t q1, input logic rst);
    logic e0, e1, busy, rnow;
    @(posedge clk);
    #1;
    cyc++;
    reset          = rst;
    bus.req0_valid = q0.v;
    bus.req0_op    = q0.op;
    bus.req0_a     = q0.a;
    bus.req0_b     = q0.b;
    bus.req1_valid = q1.v;
    bus.req1_op    = q1.op;
    bus.req1_a     = q1.a;
    bus.req1_b     = q1.b;
    busy = (cyc >= busy_lo) && (cyc <= busy_hi);
    if (busy) begin
      bus.alu_done   = (cyc == done_cyc);
      bus.alu_result = (cyc == done_cyc) ? alu_res_m : 16'($urandom);
    end else begin
      bus.alu_done   = ($urandom_range(3) == 0);
      bus.alu_result = 16'($urandom);
    end
    @(negedge clk);
    e0   = !rst && (cyc >= next_free) && q0.v && (!q1.v || last_g);
    e1   = !rst && (cyc >= next_free) && q1.v && (!q0.v || !last_g);
    rnow = (cyc == rsp_cyc);
    o_rdy0  = bus.req0_ready;
    o_rdy1  = bus.req1_ready;
    o_start = bus.alu_start;
    o_rv    = bus.rsp_valid;
    o_rid   = bus.rsp_id;
    o_rerr  = bus.rsp_err;
    o_res   = bus.rsp_result;
    if (o_start === 1'b1) starts++;
    if (o_rv === 1'b1) rsps++;
    chk("req0_ready", 16'(o_rdy0), 16'(e0));
    chk("req1_ready", 16'(o_rdy1), 16'(e1));
    chk("alu_start", 16'(o_start), 16'(busy));
    chk("alu_a", 16'(bus.alu_a), 16'(hold_a));
    chk("alu_b", 16'(bus.alu_b), 16'(hold_b));
    chk("alu_op", 16'(bus.alu_op), 16'(hold_op));
    chk("rsp_valid", 16'(o_rv), 16'(rnow));
    chk("rsp_id", 16'(o_rid), 16'(rnow & rsp_id_m));
    chk("rsp_err", 16'(o_rerr), 16'(rnow & rsp_err_m));
    chk("rsp_result", o_res, rnow ? rsp_res_m : 16'h0);
    if (rst) model_reset();
    else if (e0 || e1) accept(e1, e1 ? q1 : q0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1);
  end

  initial begin
    none           = mk(1'b0, 3'b0, 8'h0, 8'h0);
    reset          = 1'b1;
    bus.req0_valid = 1'b0;
    bus.req0_op    = '0;
    bus.req0_a     = '0;
    bus.req0_b     = '0;
    bus.req1_valid = 1'b0;
    bus.req1_op    = '0;
    bus.req1_a     = '0;
    bus.req1_b     = '0;
    bus.alu_done   = 1'b0;
    bus.alu_result = '0;
    repeat (2) @(posedge clk);
    model_reset();
    step(none, none, 1'b1);
    step(none, none, 1'b0);

    // add FF+01 with ALU done on the first start cycle
    force_lat = 1;
    step(mk(1'b1, OpAdd, 8'hFF, 8'h01), none, 1'b0);
    chk("t1_accept", 16'(o_rdy0), 16'h1);
    repeat (3) step(none, none, 1'b0);
    chk("t1_rsp_valid", 16'(o_rv), 16'h1);
    chk("t1_rsp_id", 16'(o_rid), 16'h0);
    chk("t1_rsp_result", o_res, 16'h0100);
    chk("t1_rsp_err", 16'(o_rerr), 16'h0);

    // req1 no_op completes locally two cycles after accept
    step(none, mk(1'b1, OpNo, 8'h12, 8'h34), 1'b0);
    chk("t4_accept", 16'(o_rdy1), 16'h1);
    starts = 0;
    repeat (2) step(none, none, 1'b0);
    chk("t4_no_start", 16'(starts), 16'h0);
    chk("t4_rsp_valid", 16'(o_rv), 16'h1);
    chk("t4_rsp_id", 16'(o_rid), 16'h1);
    chk("t4_rsp_result", o_res, 16'h0);
    chk("t4_rsp_err", 16'(o_rerr), 16'h0);

    // xor with an ALU that never finishes
    force_lat = 0;
    step(mk(1'b1, OpXor, 8'hA5, 8'h0F), none, 1'b0);
    starts = 0;
    repeat (T + 2) step(none, none, 1'b0);
    chk("t5_start_cycles", 16'(starts), 16'(T));
    chk("t5_rsp_valid", 16'(o_rv), 16'h1);
    chk("t5_rsp_err", 16'(o_rerr), 16'h1);
    chk("t5_rsp_result", o_res, 16'h0);

    // both requesters keep asking; grants alternate starting with req0
    step(none, none, 1'b1);
    force_lat = 2;
    ng = 0;
    for (int i = 0; i < 200 && ng < 8; i++) begin
      step(mk(1'b1, OpMul, 8'(i + 3), 8'h07), mk(1'b1, OpMul, 8'(i + 9), 8'h05), 1'b0);
      if (o_rdy0 === 1'b1 || o_rdy1 === 1'b1) begin
        gid[ng]  = o_rdy1;
        gcyc[ng] = cyc;
        ng++;
      end
    end
    chk("t23_grant_count", 16'(ng), 16'd8);
    for (int i = 0; i < ng; i++) chk("t23_grant_order", 16'(gid[i]), 16'(i % 2));
    if (ng >= 2) chk("t23_b2b_gap", 16'(gcyc[1] - gcyc[0]), 16'd4);

    // reset during a hanging mul drops it and restores req0 tie priority
    step(none, none, 1'b1);
    force_lat = 0;
    step(mk(1'b1, OpMul, 8'h03, 8'h05), none, 1'b0);
    chk("t6_accept", 16'(o_rdy0), 16'h1);
    repeat (3) step(none, none, 1'b0);
    step(none, none, 1'b1);
    rsps = 0;
    step(none, none, 1'b0);
    chk("t6_start_dropped", 16'(o_start), 16'h0);
    repeat (T + 2) step(none, none, 1'b0);
    chk("t6_no_rsp", 16'(rsps), 16'h0);
    step(mk(1'b1, OpAdd, 8'h01, 8'h02), mk(1'b1, OpAdd, 8'h03, 8'h04), 1'b0);
    chk("t6_tie_req0", 16'(o_rdy0), 16'h1);
    chk("t6_tie_not_req1", 16'(o_rdy1), 16'h0);

    // randomized traffic, stray alu_done and occasional resets
    force_lat = -1;
    for (int i = 0; i < 3000; i++) begin
      r0 = mk(($urandom_range(1) == 1), 3'($urandom_range(7)), 8'($urandom), 8'($urandom));
      r1 = mk(($urandom_range(1) == 1), 3'($urandom_range(7)), 8'($urandom), 8'($urandom));
      step(r0, r1, ($urandom_range(299) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
